// File: rtl/imm_pkg.sv
// Shared encodings and entry layout for the immediate extender.
// Optional MOVK/MOVN support is enabled by defining IMM_MOVK_EN.
package imm_pkg;

    localparam logic [2:0] IMM_B    = 3'b000;
    localparam logic [2:0] IMM_CBZ  = 3'b001;
    localparam logic [2:0] IMM_I    = 3'b010;
    localparam logic [2:0] IMM_D    = 3'b011;
    localparam logic [2:0] IMM_IW   = 3'b100;
    localparam logic [2:0] IMM_MOVK = 3'b101;
    localparam logic [2:0] IMM_MOVN = 3'b110;

    localparam int IMM_DW = 64;

    // Buffer slot layout at the native width; the FIFO packs {data, err} the same way.
    typedef struct packed {
        logic [IMM_DW-1:0] data;
        logic              err;
    } imm_entry_t;

endpackage

// File: rtl/imm_skid_fifo.sv
// Two-entry FIFO between the extender and execute; absorbs one cycle of backpressure
// without any combinational path from pop to the full indication.
module imm_skid_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender: decodes Ctrl, extends Imm26 to DATA_WIDTH, buffers {data, err}.
// Define IMM_MOVK_EN to enable the MOVK (101) and MOVN (110) forms.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [25:0]           Imm26,
    input  logic [2:0]            Ctrl,
    input  logic [DATA_WIDTH-1:0] RegOld,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] BusImm,
    output logic                  out_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    logic [1:0]            hw;
    logic [5:0]            sh;
    logic                  hw_ok;
    logic [DATA_WIDTH-1:0] movz;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_err;
    logic                  push;
    logic                  pop;
    logic [1:0]            count;

    assign hw    = Imm26[22:21];
    assign sh    = {hw, 4'b0000};
    assign hw_ok = ({30'd0, hw} < 32'(DATA_WIDTH / 16));
    assign movz  = DATA_WIDTH'(Imm26[20:5]) << sh;

`ifdef IMM_MOVK_EN
    logic [DATA_WIDTH-1:0] kmask;
    assign kmask = DATA_WIDTH'(16'hFFFF) << sh;
`else
    logic unused_regold;
    assign unused_regold = ^RegOld;
`endif

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (Ctrl)
            IMM_B:   ext_data = {{(DATA_WIDTH-26){Imm26[25]}}, Imm26};
            IMM_CBZ: ext_data = {{(DATA_WIDTH-19){Imm26[23]}}, Imm26[23:5]};
            IMM_I:   ext_data = {{(DATA_WIDTH-12){1'b0}}, Imm26[21:10]};
            IMM_D:   ext_data = {{(DATA_WIDTH-9){Imm26[20]}}, Imm26[20:12]};
            IMM_IW: begin
                if (hw_ok) ext_data = movz;
                else       ext_err  = 1'b1;
            end
`ifdef IMM_MOVK_EN
            // Out-of-range MOVK leaves the register untouched rather than zeroing it.
            IMM_MOVK: begin
                if (hw_ok) ext_data = (RegOld & ~kmask) | movz;
                else begin
                    ext_data = RegOld;
                    ext_err  = 1'b1;
                end
            end
            IMM_MOVN: begin
                if (hw_ok) ext_data = ~movz;
                else       ext_err  = 1'b1;
            end
`endif
            default: ext_err = 1'b1;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    imm_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .din   ({ext_data, ext_err}),
        .dout  ({BusImm, out_err}),
        .count (count)
    );

    always_ff @(posedge CLK) begin
        if (Reset)
            err_count <= '0;
        else if (push && ext_err && (err_count != {ERR_CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized + directed bench for imm_extend_pipe at DATA_WIDTH 64 and 32 side by side.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [25:0] Imm26 = '0;
    logic [2:0]  Ctrl = '0;
    logic [63:0] RegOld = '0;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] BusImm64;
    logic [7:0]  err_count64;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] BusImm32;
    logic [7:0]  err_count32;

    imm_extend_pipe #(.DATA_WIDTH(64), .ERR_CNT_W(8)) dut64 (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready64),
        .Imm26(Imm26), .Ctrl(Ctrl), .RegOld(RegOld), .out_valid(out_valid64),
        .out_ready(out_ready), .BusImm(BusImm64), .out_err(out_err64), .err_count(err_count64)
    );

    imm_extend_pipe #(.DATA_WIDTH(32), .ERR_CNT_W(8)) dut32 (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready32),
        .Imm26(Imm26), .Ctrl(Ctrl), .RegOld(RegOld[31:0]), .out_valid(out_valid32),
        .out_ready(out_ready), .BusImm(BusImm32), .out_err(out_err32), .err_count(err_count32)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: field extraction with integer arithmetic, result masked to width.
    typedef struct {
        logic [63:0] d;
        logic        e;
    } ref_t;

    function automatic ref_t ref_ext(input logic [2:0] c, input logic [25:0] imm,
                                     input logic [63:0] old, input int width);
        ref_t r;
        longint unsigned mask, v, imm16, hw, slot;
        mask  = (width == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 1);
        hw    = (imm / (1 << 21)) % 4;
        imm16 = (imm / 32) % 65536;
        slot  = 64'd1 << (16 * hw);
        r.e = 1'b0;
        v = 0;
        case (c)
            3'd0: begin v = imm % (1 << 26); if (v >= (1 << 25)) v = v - (1 << 26); end
            3'd1: begin v = (imm / 32) % (1 << 19); if (v >= (1 << 18)) v = v - (1 << 19); end
            3'd2: v = (imm / 1024) % 4096;
            3'd3: begin v = (imm / 4096) % 512; if (v >= 256) v = v - 512; end
            3'd4: if (16 * hw >= width) r.e = 1'b1; else v = imm16 * slot;
`ifdef IMM_MOVK_EN
            3'd5: begin
                if (16 * hw >= width) begin r.e = 1'b1; v = old; end
                else v = old - (((old / slot) % 65536) * slot) + imm16 * slot;
            end
            3'd6: if (16 * hw >= width) r.e = 1'b1; else v = ~(imm16 * slot);
`endif
            default: r.e = 1'b1;
        endcase
        r.d = v & mask;
        return r;
    endfunction

    typedef struct {
        logic [63:0] d64;
        logic        e64;
        logic [63:0] d32;
        logic        e32;
    } ent_t;

    ent_t q[$];
    int   ecnt64 = 0;
    int   ecnt32 = 0;

    // Scoreboard: outputs settle between edges; effects of this cycle land at the next edge.
    always @(negedge CLK) begin
        ref_t  a, b;
        ent_t  e;
        bit    acc;
        if (chk_en) begin
            chk("out_valid64", out_valid64, q.size() != 0);
            chk("out_valid32", out_valid32, q.size() != 0);
            chk("in_ready64", in_ready64, q.size() < 2);
            chk("in_ready32", in_ready32, q.size() < 2);
            if (q.size() != 0) begin
                chk("bus64", BusImm64, q[0].d64);
                chk("err64", out_err64, q[0].e64);
                chk("bus32", BusImm32, q[0].d32);
                chk("err32", out_err32, q[0].e32);
            end
            chk("errcnt64", err_count64, ecnt64);
            chk("errcnt32", err_count32, ecnt32);
        end
        if (Reset) begin
            q.delete();
            ecnt64 = 0;
            ecnt32 = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (acc) begin
                a = ref_ext(Ctrl, Imm26, RegOld, 64);
                b = ref_ext(Ctrl, Imm26, {32'd0, RegOld[31:0]}, 32);
                e.d64 = a.d; e.e64 = a.e; e.d32 = b.d; e.e32 = b.e;
                q.push_back(e);
                if (a.e && ecnt64 < 255) ecnt64++;
                if (b.e && ecnt32 < 255) ecnt32++;
            end
        end
    end

    task automatic push_req(input logic [2:0] c, input logic [25:0] i, input logic [63:0] r);
        bit acc = 1'b0;
        Ctrl = c; Imm26 = i; RegOld = r; in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (in_ready64) begin acc = 1'b1; break; end
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic dir(input string tag, input logic [2:0] c, input logic [25:0] i,
                       input logic [63:0] r, input logic [63:0] exp, input logic experr);
        push_req(c, i, r);
        @(negedge CLK);
        chk({tag, "_data"}, BusImm64, exp);
        chk({tag, "_err"}, out_err64, experr);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        chk_en = 1'b1;
        @(negedge CLK);
        chk("rst_valid", out_valid64, 1'b0);
        chk("rst_ready", in_ready64, 1'b1);
        chk("rst_bus", BusImm64, 64'd0);
        chk("rst_errcnt", err_count64, 8'd0);
        @(posedge CLK); #1;
        out_ready = 1'b1;

        // hw=2 is in range at 64 bits but not at 32.
        push_req(IMM_IW, 26'h0400000 | (26'hABCD << 5), 64'd0);
        @(negedge CLK);
        chk("w32_bus", BusImm32, 64'd0);
        chk("w32_err", out_err32, 1'b1);
        chk("w64_bus", BusImm64, 64'h0000_ABCD_0000_0000);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("w32_cnt", err_count32, 8'd1);
        @(posedge CLK); #1;

        dir("b_neg", IMM_B, 26'h3FFFFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        dir("iw_hw3", IMM_IW, 26'h0624680, 64'd0, 64'h1234_0000_0000_0000, 1'b0);
        dir("d_neg", IMM_D, 26'h0100000, 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
        dir("i_zext", IMM_I, 26'h03FFC00, 64'd0, 64'h0000_0000_0000_0FFF, 1'b0);
        dir("cbz_neg", IMM_CBZ, 26'h0800000, 64'd0, 64'hFFFF_FFFF_FFFC_0000, 1'b0);
`ifdef IMM_MOVK_EN
        dir("movk", IMM_MOVK, 26'h0200000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_FFFF, 1'b0);
        dir("movn", IMM_MOVN, 26'h0000020, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
`else
        dir("undef5", 3'b101, 26'h0200000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        dir("undef6", 3'b110, 26'h0000020, 64'd0, 64'd0, 1'b1);
`endif

        // Backpressure: third request waits until the consumer drains.
        out_ready = 1'b0;
        fork
            begin
                push_req(IMM_I, 26'h0001400, 64'd0);
                push_req(IMM_I, 26'h0002800, 64'd0);
                push_req(IMM_I, 26'h0003C00, 64'd0);
            end
            begin
                repeat (4) @(negedge CLK);
                chk("stall_ready", in_ready64, 1'b0);
                chk("stall_head", BusImm64, 64'd5);
                @(posedge CLK); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge CLK);
        #1;

        for (int n = 0; n < 300; n++) push_req(3'b111, 26'($urandom), 64'd0);
        repeat (3) @(negedge CLK);
        chk("sat64", err_count64, 8'd255);
        chk("sat32", err_count32, 8'd255);
        @(posedge CLK); #1;

        // Mid-stream reset with an input presented during the reset cycle.
        out_ready = 1'b0;
        push_req(IMM_B, 26'h0000001, 64'd0);
        push_req(IMM_B, 26'h0000002, 64'd0);
        Reset = 1'b1; in_valid = 1'b1; Ctrl = 3'b111;
        @(posedge CLK); #1;
        Reset = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        chk("flush_valid", out_valid64, 1'b0);
        chk("flush_ready", in_ready64, 1'b1);
        chk("flush_errcnt", err_count64, 8'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            Ctrl      = 3'($urandom_range(0, 7));
            Imm26     = 26'($urandom);
            RegOld    = {$urandom, $urandom};
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
